// File: rtl/ifid_skid_stage_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and the NOP instruction.
// Used by IF/ID and the later stage registers, so changes here ripple through the pipeline.
package ifid_skid_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifid_skid_stage_skid_entry.sv
// One pipeline entry: a valid bit plus PC/instruction, with load and clear controls.
// Latency: 1 cycle from load to outputs; no backpressure of its own (the owner decides).
module skid_entry
    import ifid_skid_stage_pkg::*;
#(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   clear_pc,
    input  logic [PC_WIDTH-1:0]    pc_dat_in,
    input  logic [INSTR_WIDTH-1:0] instr_dat_in,
    output logic                   vld,
    output logic [PC_WIDTH-1:0]    pc_dat,
    output logic [INSTR_WIDTH-1:0] instr_dat
);

    // clear wins over load; the PC may be kept on clear so decode sees the last PC on a drain
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld       <= 1'b0;
            pc_dat    <= '0;
            instr_dat <= NOP_INSTR;
        end else if (clear) begin
            vld       <= 1'b0;
            instr_dat <= NOP_INSTR;
            if (clear_pc) begin
                pc_dat <= '0;
            end
        end else if (load) begin
            vld       <= 1'b1;
            pc_dat    <= pc_dat_in;
            instr_dat <= instr_dat_in;
        end
    end

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID stage register with one-entry skid buffer, flush-to-NOP and saturating stall counter.
// Latency 1 cycle; InReady drops only when both entries are occupied, all outputs registered.
module ifid_skid_stage
    import ifid_skid_stage_pkg::*;
#(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_DEFAULT),
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Flush,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [PC_WIDTH-1:0]    PCIn,
    input  logic [INSTR_WIDTH-1:0] InstructionIn,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [PC_WIDTH-1:0]    PCOut,
    output logic [INSTR_WIDTH-1:0] InstructionOut,
    output logic [CNT_WIDTH-1:0]   StallCount
);

    stage_state_t           state_q;
    stage_state_t           state_d;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   main_ld;
    logic                   main_from_skid;
    logic                   main_clr;
    logic                   main_clr_pc;
    logic                   skid_ld;
    logic                   skid_clr;
    logic                   skid_vld;
    logic [PC_WIDTH-1:0]    skid_pc;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    main_pc_in;
    logic [INSTR_WIDTH-1:0] main_instr_in;

    assign in_xfer  = InValid & InReady;
    assign out_xfer = OutValid & OutReady;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_xfer) state_d = ONE;
                ONE:     if (in_xfer && !out_xfer) state_d = FULL;
                         else if (!in_xfer && out_xfer) state_d = EMPTY;
                FULL:    if (out_xfer) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        main_clr_pc    = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (Flush) begin
            main_clr    = 1'b1;
            main_clr_pc = 1'b1;
            skid_clr    = 1'b1;
        end else begin
            case (state_q)
                EMPTY: main_ld = in_xfer;
                ONE: begin
                    main_ld  = in_xfer & out_xfer;
                    skid_ld  = in_xfer & ~out_xfer;
                    main_clr = ~in_xfer & out_xfer;
                end
                FULL: begin
                    main_ld        = out_xfer & skid_vld;
                    main_from_skid = 1'b1;
                    skid_clr       = out_xfer;
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_pc_in    = main_from_skid ? skid_pc    : PCIn;
    assign main_instr_in = main_from_skid ? skid_instr : InstructionIn;

    skid_entry #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .NOP_INSTR   (NOP_INSTR)
    ) u_main (
        .Clk          (Clk),
        .Reset        (Reset),
        .load         (main_ld),
        .clear        (main_clr),
        .clear_pc     (main_clr_pc),
        .pc_dat_in    (main_pc_in),
        .instr_dat_in (main_instr_in),
        .vld          (OutValid),
        .pc_dat       (PCOut),
        .instr_dat    (InstructionOut)
    );

    // skid data returns to 0/NOP whenever it is emptied
    skid_entry #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .NOP_INSTR   (NOP_INSTR)
    ) u_skid (
        .Clk          (Clk),
        .Reset        (Reset),
        .load         (skid_ld),
        .clear        (skid_clr),
        .clear_pc     (1'b1),
        .pc_dat_in    (PCIn),
        .instr_dat_in (InstructionIn),
        .vld          (skid_vld),
        .pc_dat       (skid_pc),
        .instr_dat    (skid_instr)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            InReady <= 1'b1;
        end else begin
            InReady <= (state_d != FULL);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (OutValid && !OutReady && (StallCount != {CNT_WIDTH{1'b1}})) begin
            StallCount <= StallCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench for ifid_skid_stage: default, 4-bit-counter and 16-bit-datapath instances.
module tb_ifid_skid_stage;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int fails = 0;

    // instance A: default parameters
    logic        a_flush = 0, a_in_vld = 0, a_in_rdy, a_out_vld, a_out_rdy = 0;
    logic [31:0] a_pc_in = 0, a_instr_in = 0, a_pc_out, a_instr_out;
    logic [15:0] a_cnt;

    // instance B: 4-bit stall counter
    logic        b_flush = 0, b_in_vld = 0, b_in_rdy, b_out_vld, b_out_rdy = 0;
    logic [31:0] b_pc_in = 0, b_instr_in = 0, b_pc_out, b_instr_out;
    logic [3:0]  b_cnt;

    // instance C: 16-bit PC and instruction
    logic        c_flush = 0, c_in_vld = 0, c_in_rdy, c_out_vld, c_out_rdy = 0;
    logic [15:0] c_pc_in = 0, c_instr_in = 0, c_pc_out, c_instr_out;
    logic [15:0] c_cnt;

    ifid_skid_stage dut_a (
        .Clk(Clk), .Reset(Reset), .Flush(a_flush), .InValid(a_in_vld), .InReady(a_in_rdy),
        .PCIn(a_pc_in), .InstructionIn(a_instr_in), .OutValid(a_out_vld), .OutReady(a_out_rdy),
        .PCOut(a_pc_out), .InstructionOut(a_instr_out), .StallCount(a_cnt)
    );

    ifid_skid_stage #(.CNT_WIDTH(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .Flush(b_flush), .InValid(b_in_vld), .InReady(b_in_rdy),
        .PCIn(b_pc_in), .InstructionIn(b_instr_in), .OutValid(b_out_vld), .OutReady(b_out_rdy),
        .PCOut(b_pc_out), .InstructionOut(b_instr_out), .StallCount(b_cnt)
    );

    ifid_skid_stage #(.PC_WIDTH(16), .INSTR_WIDTH(16)) dut_c (
        .Clk(Clk), .Reset(Reset), .Flush(c_flush), .InValid(c_in_vld), .InReady(c_in_rdy),
        .PCIn(c_pc_in), .InstructionIn(c_instr_in), .OutValid(c_out_vld), .OutReady(c_out_rdy),
        .PCOut(c_pc_out), .InstructionOut(c_instr_out), .StallCount(c_cnt)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checks++; if (a_out_vld !== 1'b0) begin fails++; $display("FAIL reset_outvalid got %b exp 0", a_out_vld); end
        checks++; if (a_in_rdy !== 1'b1) begin fails++; $display("FAIL reset_inready got %b exp 1", a_in_rdy); end
        checks++; if (a_pc_out !== 32'h0) begin fails++; $display("FAIL reset_pcout got %h exp 0", a_pc_out); end
        checks++; if (a_instr_out !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", a_instr_out); end
        checks++; if (a_cnt !== 16'd0) begin fails++; $display("FAIL reset_stallcount got %0d exp 0", a_cnt); end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'hC;
        a_out_rdy = 1'b1;
        a_in_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_pc_in    = pcs[i];
            a_instr_in = (i == 0) ? 32'h2008_0005 : (32'h2008_0000 | pcs[i]);
            tick();
            checks++; if (a_out_vld !== 1'b1) begin fails++; $display("FAIL stream_vld[%0d] got %b exp 1", i, a_out_vld); end
            checks++; if (a_pc_out !== pcs[i]) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, a_pc_out, pcs[i]); end
            checks++; if (a_instr_out !== ((i == 0) ? 32'h2008_0005 : (32'h2008_0000 | pcs[i])))
                begin fails++; $display("FAIL stream_instr[%0d] got %h", i, a_instr_out); end
            checks++; if (a_in_rdy !== 1'b1) begin fails++; $display("FAIL stream_inready[%0d] got %b exp 1", i, a_in_rdy); end
        end
        a_in_vld = 1'b0;
        tick();
        checks++; if (a_out_vld !== 1'b0) begin fails++; $display("FAIL drain_vld got %b exp 0", a_out_vld); end
        checks++; if (a_pc_out !== 32'hC) begin fails++; $display("FAIL drain_pc_hold got %h exp c", a_pc_out); end
        checks++; if (a_instr_out !== 32'h0) begin fails++; $display("FAIL drain_instr_nop got %h exp 0", a_instr_out); end
    endtask

    task automatic test_backpressure();
        a_out_rdy = 1'b0;
        a_in_vld = 1'b1; a_pc_in = 32'h4; a_instr_in = 32'h1111_0004;
        tick();
        checks++; if (a_in_rdy !== 1'b1) begin fails++; $display("FAIL bp_first_inready got %b exp 1", a_in_rdy); end
        a_pc_in = 32'h8; a_instr_in = 32'h1111_0008;
        tick();
        checks++; if (a_in_rdy !== 1'b0) begin fails++; $display("FAIL bp_full_inready got %b exp 0", a_in_rdy); end
        checks++; if (a_cnt !== 16'd1) begin fails++; $display("FAIL bp_cnt1 got %0d exp 1", a_cnt); end
        // fetch keeps offering while full; nothing may be taken
        a_pc_in = 32'h99; a_instr_in = 32'h1111_0099;
        repeat (4) tick();
        checks++; if (a_cnt !== 16'd5) begin fails++; $display("FAIL bp_cnt5 got %0d exp 5", a_cnt); end
        checks++; if (a_pc_out !== 32'h4) begin fails++; $display("FAIL bp_pc_hold got %h exp 4", a_pc_out); end
        checks++; if (a_in_rdy !== 1'b0) begin fails++; $display("FAIL bp_hold_inready got %b exp 0", a_in_rdy); end
        a_in_vld = 1'b0;
        a_out_rdy = 1'b1;
        tick();
        checks++; if (a_pc_out !== 32'h8) begin fails++; $display("FAIL bp_second_pc got %h exp 8", a_pc_out); end
        checks++; if (a_instr_out !== 32'h1111_0008) begin fails++; $display("FAIL bp_second_instr got %h", a_instr_out); end
        checks++; if (a_in_rdy !== 1'b1) begin fails++; $display("FAIL bp_release_inready got %b exp 1", a_in_rdy); end
        checks++; if (a_cnt !== 16'd5) begin fails++; $display("FAIL bp_cnt_release got %0d exp 5", a_cnt); end
        tick();
        checks++; if (a_out_vld !== 1'b0) begin fails++; $display("FAIL bp_empty_vld got %b exp 0", a_out_vld); end
    endtask

    task automatic test_flush();
        a_out_rdy = 1'b0;
        a_in_vld = 1'b1; a_pc_in = 32'h20; a_instr_in = 32'h2222_0020;
        tick();
        a_pc_in = 32'h24; a_instr_in = 32'h2222_0024;
        tick();
        checks++; if (a_in_rdy !== 1'b0) begin fails++; $display("FAIL flush_pre_full got %b exp 0", a_in_rdy); end
        a_flush = 1'b1; a_out_rdy = 1'b1;
        a_pc_in = 32'h10; a_instr_in = 32'h2222_0010;
        tick();
        a_flush = 1'b0; a_in_vld = 1'b0;
        checks++; if (a_out_vld !== 1'b0) begin fails++; $display("FAIL flush_vld got %b exp 0", a_out_vld); end
        checks++; if (a_instr_out !== 32'h0) begin fails++; $display("FAIL flush_instr got %h exp 0", a_instr_out); end
        checks++; if (a_pc_out !== 32'h0) begin fails++; $display("FAIL flush_pc got %h exp 0", a_pc_out); end
        checks++; if (a_in_rdy !== 1'b1) begin fails++; $display("FAIL flush_inready got %b exp 1", a_in_rdy); end
        checks++; if (a_cnt !== 16'd6) begin fails++; $display("FAIL flush_cnt got %0d exp 6", a_cnt); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (a_out_vld !== 1'b0 || a_pc_out === 32'h10)
                begin fails++; $display("FAIL flush_dropped[%0d] vld %b pc %h exp vld 0", i, a_out_vld, a_pc_out); end
        end
    endtask

    task automatic test_flush_reset();
        a_out_rdy = 1'b0;
        a_in_vld = 1'b1; a_pc_in = 32'h30; a_instr_in = 32'h3333_0030;
        tick();
        a_in_vld = 1'b0;
        tick();
        checks++; if (a_cnt !== 16'd7) begin fails++; $display("FAIL fr_pre_cnt got %0d exp 7", a_cnt); end
        Reset = 1'b1; a_flush = 1'b1; a_in_vld = 1'b1;
        tick();
        Reset = 1'b0; a_flush = 1'b0; a_in_vld = 1'b0;
        checks++; if (a_out_vld !== 1'b0) begin fails++; $display("FAIL fr_vld got %b exp 0", a_out_vld); end
        checks++; if (a_in_rdy !== 1'b1) begin fails++; $display("FAIL fr_inready got %b exp 1", a_in_rdy); end
        checks++; if (a_pc_out !== 32'h0) begin fails++; $display("FAIL fr_pc got %h exp 0", a_pc_out); end
        checks++; if (a_instr_out !== 32'h0) begin fails++; $display("FAIL fr_instr got %h exp 0", a_instr_out); end
        checks++; if (a_cnt !== 16'd0) begin fails++; $display("FAIL fr_cnt got %0d exp 0", a_cnt); end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_cnt;
        exp_cnt = 4'd0;
        b_out_rdy = 1'b0;
        b_in_vld = 1'b1; b_pc_in = 32'h40; b_instr_in = 32'h4444_0040;
        tick();
        b_in_vld = 1'b0;
        checks++; if (b_cnt !== 4'd0) begin fails++; $display("FAIL sat_start got %0d exp 0", b_cnt); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            checks++; if (b_cnt !== exp_cnt) begin fails++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, b_cnt, exp_cnt); end
        end
        checks++; if (b_out_vld !== 1'b1 || b_pc_out !== 32'h40)
            begin fails++; $display("FAIL sat_entry vld %b pc %h exp 1 40", b_out_vld, b_pc_out); end
    endtask

    task automatic test_wide16();
        c_out_rdy = 1'b1;
        c_in_vld = 1'b1; c_pc_in = 16'hFFFE; c_instr_in = 16'hFFFE;
        tick();
        checks++; if (c_out_vld !== 1'b1) begin fails++; $display("FAIL w16_vld0 got %b exp 1", c_out_vld); end
        checks++; if (c_pc_out !== 16'hFFFE) begin fails++; $display("FAIL w16_pc0 got %h exp fffe", c_pc_out); end
        checks++; if (c_instr_out !== 16'hFFFE) begin fails++; $display("FAIL w16_instr0 got %h exp fffe", c_instr_out); end
        c_pc_in = 16'h0000; c_instr_in = 16'h0000;
        tick();
        checks++; if (c_out_vld !== 1'b1) begin fails++; $display("FAIL w16_vld1 got %b exp 1", c_out_vld); end
        checks++; if (c_pc_out !== 16'h0000) begin fails++; $display("FAIL w16_pc1 got %h exp 0000", c_pc_out); end
        checks++; if (c_in_rdy !== 1'b1) begin fails++; $display("FAIL w16_inready got %b exp 1", c_in_rdy); end
        c_in_vld = 1'b0;
        tick();
        checks++; if (c_out_vld !== 1'b0) begin fails++; $display("FAIL w16_drain got %b exp 0", c_out_vld); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_reset();
        test_saturate();
        test_wide16();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
